d_sram_bridge: RTL and testbench
================================

D_SRAM_BRIDGE -- requirements
Module: d_sram_bridge

Interface
REQ-001 Clocking and reset SHALL be one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 data_sram_en  in  1  core M-stage memory access request.
REQ-005 data_sram_wen  in  4  byte write enables; 0000 = read.
REQ-006 data_sram_addr  in  32  core byte address (virtual).
REQ-007 data_sram_wdata  in  32  byte-lane-positioned store data.
REQ-008 data_sram_rdata  out  32  registered load data, full word.
REQ-009 hasException  in  1  M-stage exception; suppresses new transaction start.
REQ-010 longest_stall  in  1  global pipeline stall (OR of all stall sources).
REQ-011 d_stall  out  1  data-side stall to the core.
REQ-012 data_req, data_wr  out  1, 1  sram-like request valid, write flag.
REQ-013 data_size  out  2  0 = byte, 1 = half, 2 = word.
REQ-014 data_addr, data_wdata  out  32, 32  sram-like address and write data.
REQ-015 data_addr_ok, data_data_ok  in  1, 1  sram-like address accept, data return/write complete.
REQ-016 data_rdata  in  32  sram-like read data, valid with data_data_ok.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-018 IDLE -> REQ when data_sram_en=1 and hasException=0; otherwise remain in IDLE with no bus activity.
REQ-019 On IDLE->REQ, data_addr, data_wdata, data_wr and data_size SHALL be latched and held constant until data_addr_ok.
REQ-020 data_req SHALL be 1 exactly in REQ.
REQ-021 REQ -> WAIT on data_addr_ok=1; data_data_ok seen while in REQ SHALL be ignored.
REQ-022 WAIT -> DONE on data_data_ok=1; data_rdata SHALL be captured into data_sram_rdata on that edge, for reads only.
REQ-023 DONE -> IDLE on the first edge with longest_stall=0; data_sram_rdata SHALL hold its value until the next read completes.
REQ-024 d_stall SHALL be combinational and equal 1 in REQ or WAIT, or in IDLE when data_sram_en=1 and hasException=0; it SHALL be 0 in DONE.
REQ-025 Once data_req has been issued, the transaction SHALL run to completion even if hasException or data_sram_en deasserts; there is no bus cancel.
REQ-026 data_wr SHALL be 1 if and only if data_sram_wen is non-zero.
REQ-027 data_size for writes: 1111 -> 2; 0011 or 1100 -> 1; single-bit wen -> 0; reads -> 2.
REQ-028 data_addr[1:0] SHALL be 00 for reads and word writes, the index of the lowest set wen bit for byte writes, and 00 or 10 for half writes.
REQ-029 Minimum load latency is one addr_ok cycle plus one data_ok cycle, so the core sees d_stall for at least 2 cycles per access.

Reset
REQ-030 While rst=1: state=IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, data_sram_rdata=0, d_stall=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction immediately; a later data_data_ok for it SHALL be ignored in IDLE.

Configuration
REQ-032 Macro D_BRIDGE_ADDR_MAP_EN: when defined, latched data_addr SHALL map kseg0/kseg1 addresses (0x8000_0000-0xBFFF_FFFF) by clearing bits [31:29], with all other addresses passed unchanged.
REQ-033 When D_BRIDGE_ADDR_MAP_EN is undefined, data_addr[31:2] SHALL equal data_sram_addr[31:2] with no translation.

Verification
REQ-034 Read: en=1, wen=0000, addr=0xBFC0_0104, addr_ok after 1 cycle, data_ok after 2 more with rdata=0x1234_5678 -> data_size=2, data_wr=0, data_sram_rdata=0x1234_5678, d_stall low in DONE, data_addr=0x1FC0_0104 with the macro and 0xBFC0_0104 without.
REQ-035 Byte store: wen=0100, addr=0x8000_0010, wdata=0x00AB_0000 -> data_wr=1, data_size=0, data_addr[1:0]=10, data_wdata unchanged.
REQ-036 Back-pressure: data_addr_ok held 0 for 5 cycles -> data_req and the latched outputs stay stable for all 5 cycles, and d_stall=1 throughout.
REQ-037 Global stall: data_data_ok arrives while longest_stall=1 for 3 more cycles -> FSM stays in DONE, d_stall=0, rdata held, then returns to IDLE on the first edge with longest_stall=0.
REQ-038 Exception: hasException=1 with en=1 in IDLE -> no data_req and d_stall=0; hasException rising in WAIT -> transaction completes normally.
REQ-039 Reset in WAIT -> outputs zeroed asynchronously; a stray data_data_ok after reset leaves data_sram_rdata=0.

Source files
------------

// File: rtl/d_sram_bridge.sv
// d_sram_bridge: bridges the core's one-cycle data sram port onto a request/handshake sram-like bus
// Ports:
//   clk, rst                      core clock, asynchronous active-high reset
//   data_sram_en/wen/addr/wdata   core M-stage access (wen 0000 = read, store data lane-positioned)
//   data_sram_rdata               registered load data, held until the next read completes
//   hasException, longest_stall   M-stage exception (blocks new starts), global pipeline stall
//   d_stall                       combinational data-side stall back to the core
//   data_req/wr/size/addr/wdata   sram-like request, held from issue until data_addr_ok
//   data_addr_ok, data_data_ok    sram-like address accept and data return / write complete
//   data_rdata                    sram-like read data, valid with data_data_ok
// Option: define D_BRIDGE_ADDR_MAP_EN to strip bits [31:29] from kseg0/kseg1 addresses.
module d_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        hasException,
  input  logic        longest_stall,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateT;
  stateT state;
  logic start;
  logic [1:0] sizeNext, lowNext;
  logic [29:0] addrHi;
  logic unusedAddr;
  assign unusedAddr = ^data_sram_addr[1:0];
  assign start = data_sram_en && !hasException;
  // gated by rst so the core is never stalled while the bridge is held in reset
  assign d_stall = !rst && (state == REQ || state == WAIT || (state == IDLE && start));
  always_comb begin
    sizeNext = (data_sram_wen == 4'b0000 || data_sram_wen == 4'b1111) ? 2'd2 :
               (data_sram_wen == 4'b0011 || data_sram_wen == 4'b1100) ? 2'd1 : 2'd0;
    // byte offset comes from the lowest enabled lane, not from the core address
    lowNext = sizeNext == 2'd2 ? 2'd0 :
              sizeNext == 2'd1 ? {data_sram_wen[3], 1'b0} :
              data_sram_wen[0] ? 2'd0 : data_sram_wen[1] ? 2'd1 : data_sram_wen[2] ? 2'd2 : 2'd3;
`ifdef D_BRIDGE_ADDR_MAP_EN
    addrHi = data_sram_addr[31:30] == 2'b10 ? {3'b000, data_sram_addr[28:2]} : data_sram_addr[31:2];
`else
    addrHi = data_sram_addr[31:2];
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      data_req <= 1'b0;
      data_wr <= 1'b0;
      data_size <= 2'd0;
      data_addr <= 32'd0;
      data_wdata <= 32'd0;
      data_sram_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= REQ;
          data_req <= 1'b1;
          data_wr <= |data_sram_wen;
          data_size <= sizeNext;
          data_addr <= {addrHi, lowNext};
          data_wdata <= data_sram_wdata;
        end
        REQ: if (data_addr_ok) begin
          state <= WAIT;
          data_req <= 1'b0;
        end
        WAIT: if (data_data_ok) begin
          state <= DONE;
          if (!data_wr) data_sram_rdata <= data_rdata;
        end
        DONE: if (!longest_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_d_sram_bridge.sv
// tb_d_sram_bridge: randomized scoreboard bench for d_sram_bridge with a spec-level request model
module tb_d_sram_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic data_sram_en = 1'b0, hasException = 1'b0, longest_stall = 1'b0;
  logic [3:0] data_sram_wen = 4'd0;
  logic [31:0] data_sram_addr = 32'd0, data_sram_wdata = 32'd0, data_sram_rdata;
  logic d_stall, data_req, data_wr;
  logic [1:0] data_size;
  logic [31:0] data_addr, data_wdata;
  logic data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'd0;
  int checks = 0, errors = 0, curTxn = 0;
  bit slaveOn = 1'b1;
  logic [31:0] lastRd = 32'd0;
  typedef struct packed {logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata;} reqT;
  reqT reqQ[$];
  logic [31:0] rdQ[$];
  localparam int NTXN = 60;
  always #5 clk = ~clk;
  d_sram_bridge dut (
    .clk(clk), .rst(rst), .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .hasException(hasException), .longest_stall(longest_stall), .d_stall(d_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic reqT model(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    reqT r;
    int ones = $countones(wen);
    logic [1:0] low = 2'd0;
    r.wr = wen != 4'd0;
    r.size = (!r.wr || ones == 4) ? 2'd2 : ones == 2 ? 2'd1 : 2'd0;
    if (r.size == 2'd0) begin
      for (int i = 3; i >= 0; i--) if (wen[i]) low = 2'(i);
    end else if (r.size == 2'd1 && wen[3]) low = 2'd2;
    r.addr = {addr[31:2], low};
`ifdef D_BRIDGE_ADDR_MAP_EN
    if (r.addr >= 32'h8000_0000 && r.addr <= 32'hBFFF_FFFF) r.addr = r.addr % 32'h2000_0000;
`endif
    r.wdata = wdata;
    return r;
  endfunction
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic present(input int n);
    logic [3:0] wenTab [8] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    curTxn = n;
    data_sram_wen = wenTab[$urandom_range(0, 7)];
    data_sram_addr = $urandom;
    data_sram_wdata = $urandom;
    if (n == 0) begin
      data_sram_wen = 4'b0000;
      data_sram_addr = 32'hBFC0_0104;
    end else if (n == 1) begin
      data_sram_wen = 4'b0100;
      data_sram_addr = 32'h8000_0010;
      data_sram_wdata = 32'h00AB_0000;
    end
    reqQ.push_back(model(data_sram_wen, data_sram_addr, data_sram_wdata));
    data_sram_en = 1'b1;
    hasException = 1'b0;
  endtask
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin : slave
    int d1, d2, rdCount;
    logic wr;
    rdCount = 0;
    forever begin
      cyc;
      if (!slaveOn || rst || !data_req) continue;
      d1 = curTxn == 0 ? 1 : curTxn == 2 ? 5 : $urandom_range(0, 3);
      d2 = curTxn == 0 ? 2 : $urandom_range(0, 3);
      repeat (d1) begin
        data_data_ok = $urandom_range(0, 3) == 0;
        data_rdata = $urandom;
        cyc;
      end
      data_data_ok = 1'b0;
      data_addr_ok = 1'b1;
      wr = data_wr;
      cyc;
      data_addr_ok = 1'b0;
      repeat (d2) cyc;
      data_data_ok = 1'b1;
      data_rdata = rdCount == 0 ? 32'h1234_5678 : $urandom;
      if (!wr) begin
        rdQ.push_back(data_rdata);
        rdCount++;
      end
      cyc;
      data_data_ok = 1'b0;
    end
  end
  initial begin : monitor
    bit dataPhase = 1'b0, pend = 1'b0, curWr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dataPhase = 1'b0;
        pend = 1'b0;
        lastRd = 32'd0;
        continue;
      end
      if (pend) begin
        check("rdata", data_sram_rdata, lastRd);
        pend = 1'b0;
      end
      if (data_req) begin
        check("reqStall", d_stall, 1);
        if (reqQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedReq: data_req=1 with no access outstanding at %0t", $time);
        end else begin
          check("addr", data_addr, reqQ[0].addr);
          check("wr", data_wr, reqQ[0].wr);
          check("size", data_size, reqQ[0].size);
          check("wdata", data_wdata, reqQ[0].wdata);
          if (data_addr_ok) begin
            curWr = reqQ[0].wr;
            void'(reqQ.pop_front());
            dataPhase = 1'b1;
          end
        end
      end else if (dataPhase && data_data_ok) begin
        dataPhase = 1'b0;
        pend = 1'b1;
        if (!curWr) begin
          if (rdQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rdQueue: read completed with no returned data recorded at %0t", $time);
          end else lastRd = rdQ.pop_front();
        end
      end
    end
  end
  initial begin : driver
    bit presented = 1'b0, excBefore, excMid, done;
    int stallN, stallCnt;
    data_sram_en = 1'b1;
    data_sram_wen = 4'hF;
    @(negedge clk);
    check("rstStall", d_stall, 0);
    check("rstReq", data_req, 0);
    check("rstWr", data_wr, 0);
    check("rstSize", data_size, 0);
    check("rstAddr", data_addr, 0);
    check("rstWdata", data_wdata, 0);
    check("rstRdata", data_sram_rdata, 0);
    cyc;
    rst = 1'b0;
    data_sram_en = 1'b0;
    for (int t = 0; t < NTXN; t++) begin
      if (!presented) begin
        excBefore = t > 2 && $urandom_range(0, 4) == 0;
        cyc;
        if (excBefore) begin
          data_sram_en = 1'b1;
          hasException = 1'b1;
          repeat (2) begin
            @(negedge clk);
            check("excStall", d_stall, 0);
            check("excReq", data_req, 0);
            cyc;
          end
        end
        present(t);
      end
      @(negedge clk);
      check("startStall", d_stall, 1);
      stallCnt = 1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        cyc;
        done = data_req;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL reqTimeout: data_req never rose for access %0d", t);
      end
      excMid = t > 2 && $urandom_range(0, 3) == 0;
      data_sram_addr = $urandom;
      data_sram_wdata = $urandom;
      data_sram_wen = 4'($urandom);
      if (excMid) begin
        hasException = 1'b1;
        data_sram_en = 1'($urandom_range(0, 1));
      end
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
        @(negedge clk);
        if (d_stall) stallCnt++;
        else done = 1'b1;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL doneTimeout: access %0d never released d_stall", t);
      end
      check("minLatency", stallCnt >= 2, 1);
      hasException = 1'b0;
      data_sram_en = 1'b0;
      stallN = t == 0 ? 3 : $urandom_range(0, 2);
      presented = 1'b0;
      if (stallN > 0) begin
        longest_stall = 1'b1;
        if (t + 1 < NTXN) begin
          present(t + 1);
          presented = 1'b1;
        end
        repeat (stallN) begin
          @(negedge clk);
          check("doneStall", d_stall, 0);
          check("heldRdata", data_sram_rdata, lastRd);
        end
        longest_stall = 1'b0;
      end
    end
    slaveOn = 1'b0;
    cyc;
    cyc;
    data_sram_en = 1'b1;
    data_sram_wen = 4'b0000;
    data_sram_addr = $urandom;
    reqQ.push_back(model(data_sram_wen, data_sram_addr, data_sram_wdata));
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      cyc;
      done = data_req;
    end
    check("rstTestReq", data_req, 1);
    data_sram_en = 1'b0;
    data_addr_ok = 1'b1;
    cyc;
    data_addr_ok = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midRstStall", d_stall, 0);
    check("midRstReq", data_req, 0);
    check("midRstWr", data_wr, 0);
    check("midRstSize", data_size, 0);
    check("midRstAddr", data_addr, 0);
    check("midRstWdata", data_wdata, 0);
    check("midRstRdata", data_sram_rdata, 0);
    @(negedge clk);
    cyc;
    rst = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = 32'hDEAD_BEEF;
    cyc;
    data_data_ok = 1'b0;
    @(negedge clk);
    check("strayRdata", data_sram_rdata, 0);
    check("strayStall", d_stall, 0);
    check("strayReq", data_req, 0);
    check("queueEmpty", reqQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
